// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker: gate opcodes and sweep FSM states.
// Imported by the interface, the reference model and the top.
package gate_sweep_checker_pkg;

    typedef logic [2:0] gate_op_t;

    localparam gate_op_t OP_AND  = 3'd0;
    localparam gate_op_t OP_OR   = 3'd1;
    localparam gate_op_t OP_NAND = 3'd2;
    localparam gate_op_t OP_NOR  = 3'd3;
    localparam gate_op_t OP_XOR  = 3'd4;
    localparam gate_op_t OP_XNOR = 3'd5;
    localparam gate_op_t OP_NOT  = 3'd6;
    localparam gate_op_t OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Control, status and stimulus/response signals between a sweep controller, the checker and the gate under test.
// The slave side is the checker; the master side is whoever starts sweeps and owns the gate output.
interface gate_sweep_checker_if
    import gate_sweep_checker_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int CNT_W = 16
);

    logic              start;
    gate_op_t          op;
    logic [N_IN-1:0]   A;
    logic              Y;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [N_IN-1:0]   first_err_vec;
    logic              first_err_valid;

    modport slave (
        input  start,
        input  op,
        input  Y,
        output A,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_err_vec,
        output first_err_valid
    );

    modport master (
        output start,
        output op,
        output Y,
        input  A,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_err_vec,
        input  first_err_valid
    );

endinterface

// File: rtl/gate_sweep_checker_ref.sv
// Combinational golden model of the gate library: expected output for a given opcode and input vector.
// Reduction ops span every input bit; NOT/BUF look only at vec[0].
module gate_ref_model
    import gate_sweep_checker_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  gate_op_t        op,
    input  logic [N_IN-1:0] vec,
    output logic            exp_y
);

    always_comb begin
        exp_y = 1'b0;
        case (op)
            OP_AND:  exp_y = &vec;
            OP_OR:   exp_y = |vec;
            OP_NAND: exp_y = ~&vec;
            OP_NOR:  exp_y = ~|vec;
            OP_XOR:  exp_y = ^vec;
            OP_XNOR: exp_y = ~^vec;
            OP_NOT:  exp_y = ~vec[0];
            OP_BUF:  exp_y = vec[0];
            default: exp_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive-sweep checker: walks every input vector onto a gate, holds it to settle, then compares Y
// against the reference model and records mismatch count and the first failing vector.
module gate_sweep_checker
    import gate_sweep_checker_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_sweep_checker_if.slave  bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    sweep_state_t       state;
    gate_op_t           op_q;
    logic [HOLD_W-1:0]  hold;
    logic [N_IN-1:0]    vec_q;
    logic [CNT_W-1:0]   err_q;
    logic [N_IN-1:0]    first_vec_q;
    logic               first_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               exp_y;

    gate_ref_model #(
        .N_IN (N_IN)
    ) u_ref (
        .op    (op_q),
        .vec   (vec_q),
        .exp_y (exp_y)
    );

    // The opcode is latched at start so the reference stays fixed even if op wanders mid-sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op_q          <= OP_AND;
            hold          <= '0;
            vec_q         <= '0;
            err_q         <= '0;
            first_vec_q   <= '0;
            first_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q          <= bus.op;
                        vec_q         <= '0;
                        err_q         <= '0;
                        pass_q        <= 1'b0;
                        first_valid_q <= 1'b0;
                        hold          <= '0;
                        busy_q        <= 1'b1;
                        state         <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (hold == HOLD_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                end

                ST_CHECK: begin
                    if (bus.Y != exp_y) begin
                        if (err_q != '1) begin
                            err_q <= err_q + CNT_W'(1);
                        end
                        if (!first_valid_q) begin
                            first_vec_q   <= vec_q;
                            first_valid_q <= 1'b1;
                        end
                    end
                    if (vec_q == '1) begin
                        busy_q <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        vec_q <= vec_q + N_IN'(1);
                        hold  <= '0;
                        state <= ST_SETTLE;
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b1;
                    pass_q <= (err_q == '0);
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.A               = vec_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_vec   = first_vec_q;
    assign bus.first_err_valid = first_valid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: three checker instances, each sweeping a bench-modelled gate,
// driven from a vector table plus hand-written restart and mid-sweep reset sequences.
module tb_gate_sweep_checker;
    import gate_sweep_checker_pkg::*;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    gate_sweep_checker_if #(.N_IN(2), .CNT_W(16)) bus0 ();
    gate_sweep_checker_if #(.N_IN(3), .CNT_W(2))  bus1 ();
    gate_sweep_checker_if #(.N_IN(4), .CNT_W(16)) bus2 ();

    // Gates under test: 2-in NOR, 3-in NAND, 4-in XOR.
    assign bus0.Y = ~|bus0.A;
    assign bus1.Y = ~&bus1.A;
    assign bus2.Y = ^bus2.A;

    gate_sweep_checker #(.N_IN(2), .HOLD_CYCLES(4), .CNT_W(16)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0)
    );
    gate_sweep_checker #(.N_IN(3), .HOLD_CYCLES(4), .CNT_W(2)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );
    gate_sweep_checker #(.N_IN(4), .HOLD_CYCLES(1), .CNT_W(16)) dut2 (
        .clk (clk), .rst_n (rst_n), .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] err;
        logic [7:0]  fvec;
        logic        fvalid;
    } obs_t;

    typedef struct {
        string       name;
        int          inst;
        gate_op_t    op;
        logic [15:0] exp_err;
        logic [7:0]  exp_fvec;
        logic        exp_fvalid;
        logic        exp_pass;
        int          exp_latency;
        int          per_vec;
        int          n_vec;
        bit          check_a;
    } vec_t;

    function automatic obs_t observe(int inst);
        obs_t o;
        o = '{a: 8'd0, busy: 1'b0, done: 1'b0, pass: 1'b0, err: 16'd0, fvec: 8'd0, fvalid: 1'b0};
        case (inst)
            0: o = '{a: 8'(bus0.A), busy: bus0.busy, done: bus0.done, pass: bus0.pass,
                     err: 16'(bus0.err_count), fvec: 8'(bus0.first_err_vec), fvalid: bus0.first_err_valid};
            1: o = '{a: 8'(bus1.A), busy: bus1.busy, done: bus1.done, pass: bus1.pass,
                     err: 16'(bus1.err_count), fvec: 8'(bus1.first_err_vec), fvalid: bus1.first_err_valid};
            default: o = '{a: 8'(bus2.A), busy: bus2.busy, done: bus2.done, pass: bus2.pass,
                     err: 16'(bus2.err_count), fvec: 8'(bus2.first_err_vec), fvalid: bus2.first_err_valid};
        endcase
        return o;
    endfunction

    task automatic driveStart(input int inst, input logic v, input gate_op_t op);
        case (inst)
            0: begin bus0.start = v; bus0.op = op; end
            1: begin bus1.start = v; bus1.op = op; end
            default: begin bus2.start = v; bus2.op = op; end
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts one sweep and follows it to the done pulse; latency counts edges after the start edge.
    task automatic applyStimulus(input vec_t v);
        obs_t o;
        int   k;
        bit   seen;
        @(negedge clk);
        driveStart(v.inst, 1'b1, v.op);
        @(posedge clk);
        #1;
        driveStart(v.inst, 1'b0, v.op);
        o = observe(v.inst);
        checkOutput({v.name, "_busy_at_start"}, 32'(o.busy), 32'd1);
        if (v.check_a) checkOutput({v.name, "_a_0"}, 32'(o.a), 32'd0);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 400) begin
            @(posedge clk);
            #1;
            k++;
            o = observe(v.inst);
            if (v.check_a && k < v.per_vec * v.n_vec)
                checkOutput($sformatf("%s_a_%0d", v.name, k), 32'(o.a), 32'(k / v.per_vec));
            seen = o.done;
        end
        checkOutput({v.name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({v.name, "_latency"}, 32'(k), 32'(v.exp_latency));
        checkOutput({v.name, "_busy_at_done"}, 32'(o.busy), 32'd0);
        checkOutput({v.name, "_err_count"}, 32'(o.err), 32'(v.exp_err));
        checkOutput({v.name, "_first_valid"}, 32'(o.fvalid), 32'(v.exp_fvalid));
        if (v.exp_fvalid) checkOutput({v.name, "_first_vec"}, 32'(o.fvec), 32'(v.exp_fvec));
        checkOutput({v.name, "_pass"}, 32'(o.pass), 32'(v.exp_pass));
        @(posedge clk);
        #1;
        o = observe(v.inst);
        checkOutput({v.name, "_done_one_cycle"}, 32'(o.done), 32'd0);
    endtask

    vec_t table_v[5];

    initial begin
        obs_t o;
        int   k;
        bit   seen;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        driveStart(0, 1'b0, OP_AND);
        driveStart(1, 1'b0, OP_AND);
        driveStart(2, 1'b0, OP_AND);

        table_v[0] = '{"nor_pass",   0, OP_NOR,  16'd0, 8'd0, 1'b0, 1'b1, 21, 5, 4,  1'b0};
        table_v[1] = '{"and_on_nor", 0, OP_AND,  16'd2, 8'd0, 1'b1, 1'b0, 21, 5, 4,  1'b1};
        table_v[2] = '{"xnor_on_nor",0, OP_XNOR, 16'd1, 8'd3, 1'b1, 1'b0, 21, 5, 4,  1'b0};
        table_v[3] = '{"sat_cnt",    1, OP_AND,  16'd3, 8'd0, 1'b1, 1'b0, 41, 5, 8,  1'b0};
        table_v[4] = '{"xor4_h1",    2, OP_XOR,  16'd0, 8'd0, 1'b0, 1'b1, 33, 2, 16, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            o = observe(i);
            checkOutput($sformatf("reset_a_%0d", i), 32'(o.a), 32'd0);
            checkOutput($sformatf("reset_busy_%0d", i), 32'(o.busy), 32'd0);
            checkOutput($sformatf("reset_done_%0d", i), 32'(o.done), 32'd0);
            checkOutput($sformatf("reset_pass_%0d", i), 32'(o.pass), 32'd0);
            checkOutput($sformatf("reset_err_%0d", i), 32'(o.err), 32'd0);
            checkOutput($sformatf("reset_fvalid_%0d", i), 32'(o.fvalid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) applyStimulus(table_v[i]);

        // Re-pulse start and change op mid-sweep: result must still be the clean NOR sweep.
        @(negedge clk);
        driveStart(0, 1'b1, OP_NOR);
        @(posedge clk);
        #1;
        driveStart(0, 1'b0, OP_NOR);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 400) begin
            @(negedge clk);
            if (k == 6) driveStart(0, 1'b1, OP_AND);
            else        driveStart(0, 1'b0, OP_AND);
            @(posedge clk);
            #1;
            k++;
            seen = observe(0).done;
        end
        o = observe(0);
        checkOutput("restart_done_seen", 32'(seen), 32'd1);
        checkOutput("restart_latency", 32'(k), 32'd21);
        checkOutput("restart_err_count", 32'(o.err), 32'd0);
        checkOutput("restart_pass", 32'(o.pass), 32'd1);
        checkOutput("restart_first_valid", 32'(o.fvalid), 32'd0);

        // Mid-sweep reset during vector 2 after one mismatch has been counted.
        @(negedge clk);
        driveStart(0, 1'b1, OP_AND);
        @(posedge clk);
        #1;
        driveStart(0, 1'b0, OP_AND);
        k = 0;
        while (observe(0).a != 8'd2 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("midreset_reached_vec2", 32'(observe(0).a), 32'd2);
        checkOutput("midreset_err_before", 32'(observe(0).err), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        o = observe(0);
        checkOutput("midreset_a", 32'(o.a), 32'd0);
        checkOutput("midreset_busy", 32'(o.busy), 32'd0);
        checkOutput("midreset_err", 32'(o.err), 32'd0);
        checkOutput("midreset_fvalid", 32'(o.fvalid), 32'd0);
        checkOutput("midreset_pass", 32'(o.pass), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (observe(0).done || observe(0).busy) seen = 1'b1;
        end
        checkOutput("midreset_no_done", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
